// File: rtl/adc_sar_pkg.sv
// Shared state encoding, width helper and channel-scan search for the SAR
// ADC sequencer.
package adc_sar_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_CONVERT,
      ST_ACCUM,
      ST_OUTPUT
   } state_t;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } ch_pick_t;

   // Accumulator width: one converted code times at most 2^max_avg_log2 samples.
   function automatic int unsigned acc_w(input int unsigned resolution,
                                         input int unsigned max_avg_log2);
      return resolution + max_avg_log2;
   endfunction

   // Lowest set bit strictly above cur; when none exists and wrap is set,
   // the lowest set bit overall.
   function automatic ch_pick_t next_channel(input logic [15:0] mask,
                                             input logic [3:0]  cur,
                                             input logic        wrap);
      ch_pick_t    pick;
      int unsigned cur_i;
      pick  = '0;
      cur_i = 32'(cur);
      for (int unsigned i = 0; i < 16; i++) begin
         if (!pick.found && mask[i[3:0]] && (i > cur_i)) begin
            pick.found = 1'b1;
            pick.idx   = i[3:0];
         end
      end
      if (!pick.found && wrap) begin
         for (int unsigned i = 0; i < 16; i++) begin
            if (!pick.found && mask[i[3:0]]) begin
               pick.found = 1'b1;
               pick.idx   = i[3:0];
            end
         end
      end
      return pick;
   endfunction

   // Nothing lies above index 15, so the search falls through to the wrap.
   function automatic ch_pick_t lowest_channel(input logic [15:0] mask);
      return next_channel(mask, 4'hF, 1'b1);
   endfunction

endpackage

// File: rtl/adc_sar_bit_engine.sv
// Successive-approximation register: walks a one-hot trial bit from MSB to LSB,
// keeping each bit the comparator accepts.
module adc_sar_bit_engine #(
   parameter int unsigned RESOLUTION = 12
) (
   input  logic                  clk_dig_in,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic                  comparator,
   output logic [RESOLUTION-1:0] trial_code,
   output logic [RESOLUTION-1:0] final_code,
   output logic                  done
);

   logic [RESOLUTION-1:0] code_q;
   logic [RESOLUTION-1:0] bit_q;

   always_ff @(posedge clk_dig_in or posedge rst) begin
      if (rst) begin
         code_q <= '0;
         bit_q  <= '0;
      end else if (load) begin
         code_q <= '0;
         bit_q  <= {1'b1, {(RESOLUTION-1){1'b0}}};
      end else if (step) begin
         if (comparator) begin
            code_q <= code_q | bit_q;
         end
         bit_q <= bit_q >> 1;
      end
   end

   assign trial_code = code_q | bit_q;
   assign final_code = code_q;
   assign done       = bit_q[0];

endmodule

// File: rtl/adc_sar_sequencer.sv
// Multi-channel SAR conversion sequencer: round-robin over a channel mask,
// averaging 2^k conversions per channel into one result strobe.
module adc_sar_sequencer
   import adc_sar_pkg::*;
#(
   parameter int unsigned RESOLUTION    = 12,
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned SAMPLE_CYCLES = 2,
   parameter int unsigned MAX_AVG_LOG2  = 4
) (
   input  logic                                          clk_dig_in,
   input  logic                                          rst,
   input  logic                                          start_in,
   input  logic                                          abort_in,
   input  logic                                          continuous_in,
   input  logic [NUM_CH-1:0]                             channel_mask_in,
   input  logic [$clog2(MAX_AVG_LOG2+1)-1:0]             avg_log2_in,
   input  logic                                          comparator_in,
   output logic                                          sample_out,
   output logic                                          comp_strobe_out,
   output logic [RESOLUTION-1:0]                         dac_code_out,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] channel_sel_out,
   output logic [RESOLUTION-1:0]                         result_out,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] result_channel_out,
   output logic                                          result_valid_out,
   output logic                                          busy_out
);

   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned KW    = $clog2(MAX_AVG_LOG2+1);
   localparam int unsigned ACC_W = acc_w(RESOLUTION, MAX_AVG_LOG2);
   localparam int unsigned CNT_W = MAX_AVG_LOG2 + 1;
   localparam int unsigned SC_W  = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

   state_t                state_q, state_d;
   logic [NUM_CH-1:0]     mask_q;
   logic                  cont_q;
   logic [KW-1:0]         k_q, k_clamped;
   logic [CH_W-1:0]       ch_q, ch_d;
   logic [SC_W-1:0]       samp_cnt_q;
   logic [CNT_W-1:0]      avg_cnt_q;
   logic [ACC_W-1:0]      acc_q, acc_sum;
   logic [RESOLUTION-1:0] result_q;
   logic [CH_W-1:0]       result_ch_q;
   logic                  load_cfg, acc_add, avg_last, out_clear;
   logic                  eng_load, eng_step, eng_done;
   logic [RESOLUTION-1:0] eng_trial, eng_final;
   ch_pick_t              start_pick, next_pick;

   adc_sar_bit_engine #(.RESOLUTION(RESOLUTION)) u_bit_engine (
      .clk_dig_in (clk_dig_in),
      .rst        (rst),
      .load       (eng_load),
      .step       (eng_step),
      .comparator (comparator_in),
      .trial_code (eng_trial),
      .final_code (eng_final),
      .done       (eng_done)
   );

   assign k_clamped  = (avg_log2_in > KW'(MAX_AVG_LOG2)) ? KW'(MAX_AVG_LOG2) : avg_log2_in;
   assign acc_sum    = acc_q + ACC_W'(eng_final);
   assign avg_last   = (avg_cnt_q + CNT_W'(1)) == (CNT_W'(1) << k_q);
   assign start_pick = lowest_channel(16'(channel_mask_in));
   assign next_pick  = next_channel(16'(mask_q), 4'(ch_q), cont_q);

   always_ff @(posedge clk_dig_in or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      ch_d             = ch_q;
      load_cfg         = 1'b0;
      eng_load         = 1'b0;
      eng_step         = 1'b0;
      acc_add          = 1'b0;
      out_clear        = 1'b0;
      sample_out       = 1'b0;
      comp_strobe_out  = 1'b0;
      result_valid_out = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_in && (channel_mask_in != '0)) begin
               load_cfg = 1'b1;
               ch_d     = CH_W'(start_pick.idx);
               state_d  = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            sample_out = 1'b1;
            eng_load   = 1'b1;
            if (samp_cnt_q == SC_W'(SAMPLE_CYCLES-1)) begin
               state_d = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            comp_strobe_out = 1'b1;
            eng_step        = 1'b1;
            if (eng_done) begin
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            acc_add = 1'b1;
            state_d = avg_last ? ST_OUTPUT : ST_SAMPLE;
         end
         ST_OUTPUT: begin
            result_valid_out = 1'b1;
            out_clear        = 1'b1;
            if (next_pick.found) begin
               ch_d    = CH_W'(next_pick.idx);
               state_d = ST_SAMPLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort overrides everything except the OUTPUT strobe already on the wire.
      if (abort_in) begin
         state_d  = ST_IDLE;
         ch_d     = ch_q;
         load_cfg = 1'b0;
         acc_add  = 1'b0;
      end
   end

   always_ff @(posedge clk_dig_in or posedge rst) begin
      if (rst) begin
         mask_q      <= '0;
         cont_q      <= 1'b0;
         k_q         <= '0;
         ch_q        <= '0;
         samp_cnt_q  <= '0;
         avg_cnt_q   <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         result_ch_q <= '0;
      end else begin
         if (load_cfg) begin
            mask_q <= channel_mask_in;
            cont_q <= continuous_in;
            k_q    <= k_clamped;
         end
         ch_q <= ch_d;
         if ((state_q == ST_SAMPLE) && (state_d == ST_SAMPLE)) begin
            samp_cnt_q <= samp_cnt_q + SC_W'(1);
         end else begin
            samp_cnt_q <= '0;
         end
         // The result register is loaded on the final ACCUM so OUTPUT can present it directly.
         if (abort_in || out_clear) begin
            acc_q     <= '0;
            avg_cnt_q <= '0;
         end else if (acc_add) begin
            acc_q     <= acc_sum;
            avg_cnt_q <= avg_cnt_q + CNT_W'(1);
            if (avg_last) begin
               result_q    <= RESOLUTION'(acc_sum >> k_q);
               result_ch_q <= ch_q;
            end
         end
      end
   end

   assign dac_code_out       = (state_q == ST_CONVERT) ? eng_trial : '0;
   assign channel_sel_out    = ch_q;
   assign result_out         = result_q;
   assign result_channel_out = result_ch_q;
   assign busy_out           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Bench for adc_sar_sequencer: an analog channel model drives the comparator and
// a plain-arithmetic averaging model predicts the result strobes.
`timescale 1ns/1ps
module tb_adc_sar_sequencer;

   localparam int unsigned RES  = 12;
   localparam int unsigned NCH  = 4;
   localparam int unsigned SC   = 2;
   localparam int unsigned MAXK = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_in = 1'b0;
   logic        abort_in = 1'b0;
   logic        continuous_in = 1'b0;
   logic [3:0]  channel_mask_in = '0;
   logic [2:0]  avg_log2_in = '0;
   logic        comparator_in;
   logic        sample_out, comp_strobe_out, result_valid_out, busy_out;
   logic [11:0] dac_code_out, result_out;
   logic [1:0]  channel_sel_out, result_channel_out;

   int checks   = 0;
   int failures = 0;

   int unsigned base [NCH];
   logic        dither = 1'b0;
   int unsigned conv_idx = 0;

   typedef struct {
      int unsigned ch;
      int unsigned val;
   } res_t;
   res_t res_q[$];
   res_t exp_q[$];

   adc_sar_sequencer #(
      .RESOLUTION   (RES),
      .NUM_CH       (NCH),
      .SAMPLE_CYCLES(SC),
      .MAX_AVG_LOG2 (MAXK)
   ) dut (
      .clk_dig_in        (clk),
      .rst               (rst),
      .start_in          (start_in),
      .abort_in          (abort_in),
      .continuous_in     (continuous_in),
      .channel_mask_in   (channel_mask_in),
      .avg_log2_in       (avg_log2_in),
      .comparator_in     (comparator_in),
      .sample_out        (sample_out),
      .comp_strobe_out   (comp_strobe_out),
      .dac_code_out      (dac_code_out),
      .channel_sel_out   (channel_sel_out),
      .result_out        (result_out),
      .result_channel_out(result_channel_out),
      .result_valid_out  (result_valid_out),
      .busy_out          (busy_out)
   );

   always #5 clk = ~clk;

   // Analog input: per-channel level, optionally dithered by conversion number.
   always_comb comparator_in = ((base[channel_sel_out] + (dither ? (conv_idx % 4) : 32'd0))
                                >= 32'(dac_code_out));

   always @(posedge sample_out) conv_idx <= conv_idx + 1;

   always @(negedge clk) begin
      if (result_valid_out === 1'b1) res_q.push_back('{32'(result_channel_out), 32'(result_out)});
   end

   // Expected strobes: ascending set channels, floor of the mean of 2^k conversions.
   function automatic void build_expected(input logic [3:0] m, input int unsigned k,
                                          input int unsigned idx0);
      int unsigned idx, kc, sum;
      exp_q.delete();
      idx = idx0;
      kc  = (k > MAXK) ? MAXK : k;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
         if (m[ch[1:0]]) begin
            sum = 0;
            for (int unsigned j = 0; j < (32'd1 << kc); j++) begin
               idx++;
               sum += base[ch[1:0]] + (dither ? (idx % 4) : 32'd0);
            end
            exp_q.push_back('{ch, sum >> kc});
         end
      end
   endfunction

   task automatic do_start(input logic [3:0] m, input logic [2:0] k, input logic c);
      @(negedge clk);
      channel_mask_in = m;
      avg_log2_in     = k;
      continuous_in   = c;
      start_in        = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy_out === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({sample_out, comp_strobe_out, dac_code_out} !== '0) begin
         failures++;
         $display("FAIL reset_drive: got %0h expected 0", {sample_out, comp_strobe_out, dac_code_out});
      end
      checks++;
      if ({result_out, result_channel_out, result_valid_out} !== '0) begin
         failures++;
         $display("FAIL reset_result: got %0h expected 0", {result_out, result_channel_out, result_valid_out});
      end
      checks++;
      if ({channel_sel_out, busy_out} !== '0) begin
         failures++;
         $display("FAIL reset_status: got %0h expected 0", {channel_sel_out, busy_out});
      end
      rst = 1'b0;
   endtask

   task automatic test_single;
      int unsigned trace[$];
      int unsigned exp_trace[$];
      int unsigned code, trial, got_val, got_ch;
      int          first_valid;
      logic        busy_after;
      dither  = 1'b0;
      base[0] = 32'hA5C;
      res_q.delete();
      code = 0;
      for (int i = RES-1; i >= 0; i--) begin
         trial = code | (32'd1 << i);
         exp_trace.push_back(trial);
         if (base[0] >= trial) code = trial;
      end
      @(negedge clk);
      channel_mask_in = 4'b0001;
      avg_log2_in     = 3'd0;
      continuous_in   = 1'b0;
      start_in        = 1'b1;
      first_valid = -1;
      got_val     = 0;
      got_ch      = 99;
      busy_after  = 1'bx;
      for (int m = 1; m <= 18; m++) begin
         @(negedge clk);
         start_in = 1'b0;
         if (comp_strobe_out === 1'b1) trace.push_back(32'(dac_code_out));
         if (result_valid_out === 1'b1 && first_valid < 0) begin
            first_valid = m;
            got_val     = 32'(result_out);
            got_ch      = 32'(result_channel_out);
         end
         if (m == 17) busy_after = busy_out;
      end
      checks++;
      if (first_valid != 16) begin
         failures++;
         $display("FAIL single_latency: got %0d expected 16", first_valid);
      end
      checks++;
      if (trace.size() != exp_trace.size()) begin
         failures++;
         $display("FAIL single_trace_len: got %0d expected %0d", trace.size(), exp_trace.size());
      end else begin
         for (int i = 0; i < trace.size(); i++) begin
            checks++;
            if (trace[i] != exp_trace[i]) begin
               failures++;
               $display("FAIL single_dac[%0d]: got %0h expected %0h", i, trace[i], exp_trace[i]);
            end
         end
      end
      checks++;
      if (got_val != 32'hA5C || got_ch != 0) begin
         failures++;
         $display("FAIL single_result: got ch%0d=%0h expected ch0=a5c", got_ch, got_val);
      end
      checks++;
      if (busy_after !== 1'b0) begin
         failures++;
         $display("FAIL single_busy_fall: got %b expected 0", busy_after);
      end
   endtask

   task automatic test_two_channels;
      int unsigned idx0;
      bit          ok;
      dither  = 1'b0;
      base[1] = 32'h123;
      base[3] = 32'hFFF;
      res_q.delete();
      idx0 = conv_idx;
      do_start(4'b1010, 3'd0, 1'b0);
      wait_idle(200, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL two_ch_idle: got busy expected idle");
      end
      build_expected(4'b1010, 0, idx0);
      checks++;
      if (res_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL two_ch_count: got %0d expected %0d", res_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < res_q.size(); i++) begin
            checks++;
            if (res_q[i].ch != exp_q[i].ch || res_q[i].val != exp_q[i].val) begin
               failures++;
               $display("FAIL two_ch[%0d]: got ch%0d=%0h expected ch%0d=%0h", i,
                        res_q[i].ch, res_q[i].val, exp_q[i].ch, exp_q[i].val);
            end
         end
      end
   endtask

   task automatic test_average;
      bit ok;
      dither  = 1'b1;
      base[0] = 32'h100;
      res_q.delete();
      do_start(4'b0001, 3'd2, 1'b0);
      wait_idle(300, ok);
      checks++;
      if (!ok || res_q.size() != 1) begin
         failures++;
         $display("FAIL avg_count: got %0d strobes (idle=%0b) expected 1", res_q.size(), ok);
      end else begin
         checks++;
         if (res_q[0].val != 32'h101 || res_q[0].ch != 0) begin
            failures++;
            $display("FAIL avg_result: got ch%0d=%0h expected ch0=101", res_q[0].ch, res_q[0].val);
         end
      end
      dither = 1'b0;
   endtask

   task automatic test_continuous_abort;
      int unsigned idx0;
      int          n;
      bit          ok;
      dither  = 1'b0;
      base[0] = $urandom_range(0, 4095);
      base[2] = $urandom_range(0, 4095);
      res_q.delete();
      idx0 = conv_idx;
      do_start(4'b0101, 3'd0, 1'b1);
      continuous_in = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (res_q.size() >= 4) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL cont_strobes: got %0d expected 4", res_q.size());
      end
      build_expected(4'b0101, 0, idx0);
      for (int i = 0; i < 4 && i < res_q.size(); i++) begin
         checks++;
         if (res_q[i].ch != exp_q[i % 2].ch || res_q[i].val != exp_q[i % 2].val) begin
            failures++;
            $display("FAIL cont[%0d]: got ch%0d=%0h expected ch%0d=%0h", i,
                     res_q[i].ch, res_q[i].val, exp_q[i % 2].ch, exp_q[i % 2].val);
         end
      end
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sample_out === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      for (int i = 0; i < 40 && ok; i++) begin
         @(negedge clk);
         if (comp_strobe_out === 1'b1) break;
      end
      repeat (3) @(negedge clk);
      abort_in        = 1'b1;
      start_in        = 1'b1;
      channel_mask_in = 4'b1111;
      @(negedge clk);
      abort_in = 1'b0;
      start_in = 1'b0;
      checks++;
      if ({busy_out, sample_out, comp_strobe_out, dac_code_out} !== '0) begin
         failures++;
         $display("FAIL abort_outputs: got %0h expected 0",
                  {busy_out, sample_out, comp_strobe_out, dac_code_out});
      end
      n = res_q.size();
      repeat (60) @(negedge clk);
      checks++;
      if (res_q.size() != n || busy_out !== 1'b0) begin
         failures++;
         $display("FAIL abort_quiet: got %0d strobes busy=%b expected %0d busy=0",
                  res_q.size(), busy_out, n);
      end
   endtask

   task automatic test_ignored_start;
      int unsigned idx0;
      bit          ok, seen_busy;
      dither = 1'b0;
      res_q.delete();
      @(negedge clk);
      channel_mask_in = 4'b0000;
      start_in        = 1'b1;
      @(negedge clk);
      start_in  = 1'b0;
      seen_busy = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (busy_out !== 1'b0) seen_busy = 1'b1;
      end
      checks++;
      if (seen_busy || res_q.size() != 0) begin
         failures++;
         $display("FAIL zero_mask: got busy=%b strobes=%0d expected busy=0 strobes=0",
                  seen_busy, res_q.size());
      end
      base[1] = $urandom_range(0, 4095);
      idx0 = conv_idx;
      do_start(4'b0010, 3'd1, 1'b0);
      repeat (5) @(negedge clk);
      channel_mask_in = 4'b1111;
      avg_log2_in     = 3'd0;
      continuous_in   = 1'b1;
      start_in        = 1'b1;
      @(negedge clk);
      start_in      = 1'b0;
      continuous_in = 1'b0;
      wait_idle(200, ok);
      build_expected(4'b0010, 1, idx0);
      checks++;
      if (!ok || res_q.size() != 1 || res_q[0].ch != exp_q[0].ch || res_q[0].val != exp_q[0].val) begin
         failures++;
         $display("FAIL start_midscan: got %0d strobes (idle=%0b) expected ch%0d=%0h only",
                  res_q.size(), ok, exp_q[0].ch, exp_q[0].val);
      end
   endtask

   task automatic test_async_reset;
      bit ok;
      dither  = 1'b0;
      base[0] = $urandom_range(0, 4095);
      do_start(4'b0001, 3'd0, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (comp_strobe_out === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL areset_convert: got no comp strobe expected one");
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({sample_out, comp_strobe_out, dac_code_out, busy_out, channel_sel_out} !== '0) begin
         failures++;
         $display("FAIL areset_drive: got %0h expected 0",
                  {sample_out, comp_strobe_out, dac_code_out, busy_out, channel_sel_out});
      end
      checks++;
      if ({result_out, result_channel_out, result_valid_out} !== '0) begin
         failures++;
         $display("FAIL areset_result: got %0h expected 0", {result_out, result_channel_out, result_valid_out});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      res_q.delete();
      do_start(4'b0001, 3'd0, 1'b0);
      wait_idle(100, ok);
      checks++;
      if (!ok || res_q.size() != 1 || res_q[0].val != base[0] || res_q[0].ch != 0) begin
         failures++;
         $display("FAIL areset_restart: got %0d strobes first=%0h expected 1 strobe ch0=%0h",
                  res_q.size(), (res_q.size() > 0) ? res_q[0].val : 32'hFFFF_FFFF, base[0]);
      end
   endtask

   task automatic test_random;
      int unsigned idx0, k;
      logic [3:0]  m;
      bit          ok;
      dither = 1'b1;
      for (int it = 0; it < 6; it++) begin
         m = 4'($urandom_range(1, 15));
         k = $urandom_range(0, 7);
         for (int unsigned ch = 0; ch < NCH; ch++) base[ch[1:0]] = $urandom_range(0, 4092);
         res_q.delete();
         idx0 = conv_idx;
         do_start(m, 3'(k), 1'b0);
         repeat (3) @(negedge clk);
         channel_mask_in = 4'($urandom);
         avg_log2_in     = 3'($urandom);
         wait_idle(1500, ok);
         build_expected(m, k, idx0);
         checks++;
         if (!ok || res_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand%0d_count: got %0d (idle=%0b) expected %0d", it, res_q.size(), ok, exp_q.size());
         end else begin
            for (int i = 0; i < res_q.size(); i++) begin
               checks++;
               if (res_q[i].ch != exp_q[i].ch || res_q[i].val != exp_q[i].val) begin
                  failures++;
                  $display("FAIL rand%0d[%0d]: got ch%0d=%0h expected ch%0d=%0h (mask=%b k=%0d)", it, i,
                           res_q[i].ch, res_q[i].val, exp_q[i].ch, exp_q[i].val, m, k);
               end
            end
         end
      end
      dither = 1'b0;
   endtask

   initial begin
      test_reset;
      test_single;
      test_two_channels;
      test_average;
      test_continuous_abort;
      test_ignored_start;
      test_async_reset;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
